lbist_misr: RTL and testbench

Multiple-input signature register (MISR) stage for the LBIST chain. It sits directly downstream of the `buft` buffer stage and consumes both of its 8-bit outputs (`data1`, `data2`). Over a programmed number of valid pattern cycles it compresses them into one signature, then compares that signature against a golden value and reports pass/fail.

---
 rtl/lbist_misr_if.sv | 40 ++++
 rtl/lbist_misr.sv | 114 +++++++++++
 tb/tb_lbist_misr.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lbist_misr_if.sv
// Bus bundle between the LBIST response source and the MISR stage.
// The xmask field exists only when LBIST_MISR_XMASK_EN is defined.
interface lbist_misr_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = 16;

    logic             start;
    logic             valid;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
`ifdef LBIST_MISR_XMASK_EN
    logic [WIDTH-1:0] xmask;
`endif
    logic [WIDTH-1:0] sig;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             pass;

`ifdef LBIST_MISR_XMASK_EN
    modport master (
        output start, valid, data1, data2, xmask,
        input  sig, count, busy, done, pass
    );
    modport slave (
        input  start, valid, data1, data2, xmask,
        output sig, count, busy, done, pass
    );
`else
    modport master (
        output start, valid, data1, data2,
        input  sig, count, busy, done, pass
    );
    modport slave (
        input  start, valid, data1, data2,
        output sig, count, busy, done, pass
    );
`endif
endinterface

// File: rtl/lbist_misr.sv
// MISR signature compressor with golden compare for the LBIST chain.
// Optional X-masking of response bits is enabled with LBIST_MISR_XMASK_EN.
module lbist_misr #(
    parameter int unsigned     WIDTH    = 8,
    parameter int unsigned     PATTERNS = 40,
    parameter logic [WIDTH-1:0] SEED    = 8'h00,
    parameter logic [WIDTH-1:0] POLY    = 8'hB8,
    parameter logic [WIDTH-1:0] GOLDEN  = 8'h00
) (
    input logic          clk,
    input logic          rst_n,
    lbist_misr_if.slave  bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned HALF  = WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] d1_m;
    logic [WIDTH-1:0] d2_m;
    logic [WIDTH-1:0] in_vec;
    logic             fb;
    logic [WIDTH-1:0] sig_next;
    logic             last_sample;

    // Response masking and nibble-swapped combine of the two words
    always_comb begin
`ifdef LBIST_MISR_XMASK_EN
        d1_m = bus.data1 & ~bus.xmask;
        d2_m = bus.data2 & ~bus.xmask;
`else
        d1_m = bus.data1;
        d2_m = bus.data2;
`endif
        in_vec = d1_m ^ {d2_m[HALF-1:0], d2_m[WIDTH-1:HALF]};
    end

    // One compression step of the signature register
    always_comb begin
        fb          = ^(sig_q & POLY);
        sig_next    = {sig_q[WIDTH-2:0], fb} ^ in_vec;
        last_sample = (count_q == CNT_W'(PATTERNS - 1));
    end

    // Next-state and register-input logic
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        pass_d  = pass_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    pass_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.valid) begin
                    sig_d   = sig_next;
                    count_d = count_q + CNT_W'(1);
                    if (last_sample) begin
                        pass_d  = (sig_next == GOLDEN);
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sig   = sig_q;
    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.pass  = pass_q;
endmodule

// File: tb/tb_lbist_misr.sv
// Randomised and directed bench for lbist_misr against a behavioural signature model.
module tb_lbist_misr;
    localparam int unsigned W        = 8;
    localparam int unsigned PATTERNS = 4;
    localparam logic [7:0]  SEED     = 8'h00;
    localparam logic [7:0]  POLY     = 8'hB8;
    localparam logic [7:0]  GOLDEN   = 8'h0F;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    lbist_misr_if #(.WIDTH(W)) bus ();

    lbist_misr #(
        .WIDTH(W), .PATTERNS(PATTERNS), .SEED(SEED), .POLY(POLY), .GOLDEN(GOLDEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference signature step from the compression rule, in plain integers
    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d1,
                                             input logic [7:0] d2, input logic [7:0] xm);
        int a, b, swapped, fb, shifted;
        a       = int'(d1 & ~xm);
        b       = int'(d2 & ~xm);
        swapped = ((b * 16) + (b / 16)) % 256;
        fb      = $countones(s & POLY) % 2;
        shifted = (int'(s) * 2 + fb) % 256;
        return 8'(shifted ^ a ^ swapped);
    endfunction

    // Behavioural model: a run is "active" until PATTERNS samples are absorbed
    logic [7:0] m_sig;
    int         m_count;
    bit         m_active, m_finished, m_pass;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] xm;
        if (!rst_n) begin
            m_sig = SEED; m_count = 0; m_active = 0; m_finished = 0; m_pass = 0;
        end else begin
`ifdef LBIST_MISR_XMASK_EN
            xm = bus.xmask;
`else
            xm = 8'h00;
`endif
            if (m_active) begin
                if (bus.valid) begin
                    m_sig = misr_step(m_sig, bus.data1, bus.data2, xm);
                    m_count = m_count + 1;
                    if (m_count == PATTERNS) begin
                        m_active = 0; m_finished = 1; m_pass = (m_sig == GOLDEN);
                    end
                end
            end else if (bus.start) begin
                m_sig = SEED; m_count = 0; m_active = 1; m_finished = 0; m_pass = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("sig",   32'(bus.sig),   32'(m_sig));
            chk("count", 32'(bus.count), 32'(m_count));
            chk("busy",  32'(bus.busy),  32'(m_active));
            chk("done",  32'(bus.done),  32'(m_finished));
            chk("pass",  32'(bus.pass),  32'(m_pass));
        end
    end

    task automatic drive(input bit st, input bit v, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] xm);
        bus.start = st;
        bus.valid = v;
        bus.data1 = d1;
        bus.data2 = d2;
`ifdef LBIST_MISR_XMASK_EN
        bus.xmask = xm;
`endif
        @(negedge clk);
    endtask

    task automatic run_basic(input logic [7:0] xm);
        drive(1, 0, 8'h00, 8'h00, xm);
        for (int i = 0; i < 4; i++) drive(0, 1, 8'h01, 8'h00, xm);
        drive(0, 0, 8'h00, 8'h00, xm);
    endtask

    initial begin
        logic [7:0] exp_steps [4];
        int         busy_cycles;
        exp_steps[0] = 8'h01; exp_steps[1] = 8'h03; exp_steps[2] = 8'h07; exp_steps[3] = 8'h0F;

        rst_n = 1'b0;
        bus.start = 0; bus.valid = 0; bus.data1 = '0; bus.data2 = '0;
`ifdef LBIST_MISR_XMASK_EN
        bus.xmask = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_sig", 32'(bus.sig), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic compression with literal signature sequence
        drive(1, 0, 8'h00, 8'h00, 8'h00);
        chk("lit_busy_after_start", 32'(bus.busy), 32'h1);
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.busy) busy_cycles++;
            drive(0, 1, 8'h01, 8'h00, 8'h00);
            chk("lit_sig_step", 32'(bus.sig), 32'(exp_steps[i]));
        end
        chk("lit_busy_cycles", 32'(busy_cycles), 32'd4);
        chk("lit_count", 32'(bus.count), 32'd4);
        chk("lit_done", 32'(bus.done), 32'h1);
        chk("lit_pass", 32'(bus.pass), 32'h1);
        chk("lit_busy_end", 32'(bus.busy), 32'h0);
        drive(0, 1, 8'h55, 8'h33, 8'h00);
        chk("lit_done_hold_sig", 32'(bus.sig), 32'h0F);

        // Start from DONE clears pass and done; gaps do not alter the result
        drive(1, 0, 8'h00, 8'h00, 8'h00);
        chk("lit_restart_done", 32'(bus.done), 32'h0);
        chk("lit_restart_pass", 32'(bus.pass), 32'h0);
        begin
            bit gaps [6] = '{1, 0, 1, 0, 1, 1};
            for (int i = 0; i < 6; i++) drive(0, gaps[i], 8'h01, 8'h00, 8'h00);
        end
        chk("lit_gap_sig", 32'(bus.sig), 32'h0F);
        chk("lit_gap_pass", 32'(bus.pass), 32'h1);

        // Failing run: third sample differs
        drive(1, 0, 8'h00, 8'h00, 8'h00);
        drive(0, 1, 8'h01, 8'h00, 8'h00);
        drive(0, 1, 8'h01, 8'h00, 8'h00);
        drive(0, 1, 8'h02, 8'h00, 8'h00);
        drive(0, 1, 8'h01, 8'h00, 8'h00);
        chk("lit_fail_sig", 32'(bus.sig), 32'h09);
        chk("lit_fail_done", 32'(bus.done), 32'h1);
        chk("lit_fail_pass", 32'(bus.pass), 32'h0);

        // Start during RUN, including alongside the final sample, is ignored
        drive(1, 0, 8'h00, 8'h00, 8'h00);
        drive(0, 1, 8'h01, 8'h00, 8'h00);
        drive(1, 1, 8'h01, 8'h00, 8'h00);
        drive(1, 1, 8'h01, 8'h00, 8'h00);
        drive(1, 1, 8'h01, 8'h00, 8'h00);
        chk("lit_start_in_run_done", 32'(bus.done), 32'h1);
        chk("lit_start_in_run_sig", 32'(bus.sig), 32'h0F);
        drive(0, 0, 8'h00, 8'h00, 8'h00);

        // Asynchronous reset mid-run
        drive(1, 0, 8'h00, 8'h00, 8'h00);
        drive(0, 1, 8'h01, 8'h00, 8'h00);
        drive(0, 1, 8'h01, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_sig", 32'(bus.sig), 32'h00);
        chk("lit_rst_count", 32'(bus.count), 32'h0);
        chk("lit_rst_busy", 32'(bus.busy), 32'h0);
        chk("lit_rst_done", 32'(bus.done), 32'h0);
        chk("lit_rst_pass", 32'(bus.pass), 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive(0, 1, 8'h01, 8'h00, 8'h00);
        chk("lit_idle_after_rst_busy", 32'(bus.busy), 32'h0);
        chk("lit_idle_after_rst_count", 32'(bus.count), 32'h0);

`ifdef LBIST_MISR_XMASK_EN
        run_basic(8'h01);
        chk("lit_xmask_sig", 32'(bus.sig), 32'h00);
        chk("lit_xmask_pass", 32'(bus.pass), 32'h0);
        run_basic(8'h00);
        chk("lit_xmask0_sig", 32'(bus.sig), 32'h0F);
`else
        run_basic(8'h00);
        chk("lit_rerun_sig", 32'(bus.sig), 32'h0F);
`endif

        // Randomised traffic: starts, valid gaps, data, occasional async reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                  8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
